// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA frame controller slice:
//   - frame-update FSM state enum
//   - layer count and colour width
//   - 640x480 @ 60 Hz timing constants
//   - one-hot helper for the update-request vector
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned NUM_LAYERS = 4;
    localparam int unsigned RGB_W      = 3;

    // 640x480 horizontal timing (pixels)
    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    // 640x480 vertical timing (lines)
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } upd_state_t;

    function automatic logic [NUM_LAYERS-1:0] idx_onehot(input logic [1:0] idx);
        return NUM_LAYERS'(1) << idx;
    endfunction

endpackage

// File: rtl/vga_layer_mux.sv
// ---------------------------------------------------------------------------
// vga_layer_mux
//   Combinational priority pixel mux. Layer 0 has highest priority; when no
//   layer hits, the background colour is used. Outside the visible area the
//   output is black.
//
//   Ports
//     video_on   in   1                 visible-area flag
//     layer_on   in   NUM_LAYERS        per-layer hit flags
//     layer_rgb  in   NUM_LAYERS*RGB_W  layer i at [RGB_W*i +: RGB_W]
//     bg_rgb     in   RGB_W             background colour
//     pix_rgb    out  RGB_W             selected colour (unregistered)
// ---------------------------------------------------------------------------
module vga_layer_mux
    import vga_pkg::*;
(
    input  logic                        video_on,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    output logic [RGB_W-1:0]            pix_rgb
);

    always_comb begin
        pix_rgb = bg_rgb;
        // Walk from the lowest priority upward so the lowest index wins.
        for (int unsigned i = NUM_LAYERS; i > 0; i--) begin
            if (layer_on[i-1]) begin
                pix_rgb = layer_rgb[(i-1)*RGB_W +: RGB_W];
            end
        end
        if (!video_on) begin
            pix_rgb = '0;
        end
    end

endmodule

// File: rtl/vga_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vga_frame_ctrl
//   Registers the prioritised pixel colour and, once per frame, walks the four
//   game objects through an update handshake (req held until ack).
//
//   Parameters
//     VBLANK_LINE  pixel_y line on which the update sequence starts
//     TIMEOUT_CYC  WAIT cycles allowed per ack (timeout build only)
//
//   Ports
//     clk, reset_n           clock, async active-low reset
//     p_tick                 pixel-rate enable
//     video_on               visible-area flag
//     pixel_x, pixel_y       current pixel coordinates (10 bits each)
//     layer_on, layer_rgb    layer hit flags / colours (layer 0 highest prio)
//     bg_rgb                 background colour
//     rgb                    registered pixel colour (1 clk latency)
//     upd_req, upd_ack       one-hot request / per-object acknowledge
//     frame_tick, upd_done   single-cycle pulses
//     overrun                sticky: frame_tick seen while a sequence is active
//     timeout_err            sticky per-object ack timeout flags
//
//   Build option
//     VGA_FRAME_CTRL_TIMEOUT_EN  adds the WAIT timeout counter; without it the
//                                FSM waits indefinitely and timeout_err is 0.
// ---------------------------------------------------------------------------
module vga_frame_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned VBLANK_LINE = 480,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        p_tick,
    input  logic                        video_on,
    input  logic [9:0]                  pixel_x,
    input  logic [9:0]                  pixel_y,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    output logic [RGB_W-1:0]            rgb,
    output logic [NUM_LAYERS-1:0]       upd_req,
    input  logic [NUM_LAYERS-1:0]       upd_ack,
    output logic                        frame_tick,
    output logic                        upd_done,
    output logic                        overrun,
    output logic [NUM_LAYERS-1:0]       timeout_err
);

    upd_state_t  state, state_next;
    logic [1:0]  idx, idx_next;
    logic [RGB_W-1:0] mux_rgb;
    logic        tmo_hit;
    logic        ack_cur;

    vga_layer_mux u_layer_mux (
        .video_on  (video_on),
        .layer_on  (layer_on),
        .layer_rgb (layer_rgb),
        .bg_rgb    (bg_rgb),
        .pix_rgb   (mux_rgb)
    );

    assign ack_cur = upd_ack[idx];

`ifdef VGA_FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYC-th WAIT cycle; the counter is zero on WAIT entry.
    assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= '0;
            timeout_err <= '0;
        end else begin
            if (state != ST_WAIT || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // An ack arriving on the timeout cycle wins; no error is flagged.
            if (tmo_hit && !ack_cur) begin
                timeout_err[idx] <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = '0;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_next = ST_REQ;
                    idx_next   = '0;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_cur || tmo_hit) begin
                    if (idx == 2'd3) begin
                        state_next = ST_DONE;
                        idx_next   = '0;
                    end else begin
                        state_next = ST_REQ;
                        idx_next   = idx + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request and done are decoded from the state register, so they clear
    // together with it on reset and can never show more than one request bit.
    always_comb begin
        upd_req  = '0;
        upd_done = 1'b0;
        if (state == ST_REQ || state == ST_WAIT) begin
            upd_req = idx_onehot(idx);
        end
        if (state == ST_DONE) begin
            upd_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            rgb        <= '0;
            frame_tick <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            rgb        <= mux_rgb;
            frame_tick <= p_tick && (pixel_x == '0) && (pixel_y == 10'(VBLANK_LINE));
            if (frame_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
